// File: rtl/avalon_xbar_pkg.sv
// Shared definitions for the Avalon-MM crossbar: arbitration modes, arbiter
// states, request/response bundles and the default SoC memory map.
package avalon_xbar_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [3:0]  byte_enable;
      logic [31:0] writedata;
   } avalon_req_t;

   typedef struct packed {
      logic [31:0] readdata;
      logic        waitrequest;
   } avalon_resp_t;

   // Default SoC map, slave 0 in the least significant word.
   localparam int          SOC_N_SLV = 6;
   localparam logic [31:0] RAM_BASE  = 32'h0000_0000, RAM_MASK  = 32'hF000_0000;
   localparam logic [31:0] DBG_BASE  = 32'h1000_0000, DBG_MASK  = 32'hFFFF_0000;
   localparam logic [31:0] CLIC_BASE = 32'h2000_0000, CLIC_MASK = 32'hFFFF_0000;
   localparam logic [31:0] PLIC_BASE = 32'h3000_0000, PLIC_MASK = 32'hFFFF_0000;
   localparam logic [31:0] UART_BASE = 32'h4000_0000, UART_MASK = 32'hFFFF_F000;
   localparam logic [31:0] GPIO_BASE = 32'h4000_1000, GPIO_MASK = 32'hFFFF_F000;

   localparam logic [SOC_N_SLV*32-1:0] SOC_SLV_BASE =
      {GPIO_BASE, UART_BASE, PLIC_BASE, CLIC_BASE, DBG_BASE, RAM_BASE};
   localparam logic [SOC_N_SLV*32-1:0] SOC_SLV_MASK =
      {GPIO_MASK, UART_MASK, PLIC_MASK, CLIC_MASK, DBG_MASK, RAM_MASK};

endpackage

// File: rtl/avalon_xbar_arbiter.sv
// Per-slave arbiter: picks one requesting master, holds the slave locked to it
// while the slave stalls, and emits a one-hot grant.
module avalon_xbar_arbiter
   import avalon_xbar_pkg::*;
#(
   parameter int N_MST    = 3,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_MST-1:0] req,
   input  logic             waitrequest,
   output logic [N_MST-1:0] grant
);

   localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;

   arb_state_t    state, state_next;
   logic [PW-1:0] ptr, ptr_next, owner, owner_next, winner, idx_b;
   logic          found;

   // Round-robin scans upward from ptr with wrap; fixed mode scans from 0.
   always_comb begin
      int idx;
      idx    = 0;
      idx_b  = '0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < N_MST; i++) begin
         idx = (ARB_MODE == ARB_FIXED) ? i : int'(ptr) + i;
         if (idx >= N_MST) idx = idx - N_MST;
         idx_b = PW'(idx);
         if (!found && req[idx_b]) begin
            found  = 1'b1;
            winner = idx_b;
         end
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      owner_next = owner;
      grant      = '0;
      case (state)
         ARB_IDLE: begin
            if (found) begin
               grant[winner] = 1'b1;
               if (waitrequest) begin
                  state_next = ARB_BUSY;
                  owner_next = winner;
               end else if (ARB_MODE == ARB_RR) begin
                  ptr_next = (int'(winner) == N_MST - 1) ? '0 : winner + PW'(1);
               end
            end
         end
         ARB_BUSY: begin
            // An owner that abandons its request releases the lock rather than hanging the slave.
            grant[owner] = req[owner];
            if (!req[owner]) begin
               state_next = ARB_IDLE;
            end else if (!waitrequest) begin
               state_next = ARB_IDLE;
               if (ARB_MODE == ARB_RR)
                  ptr_next = (int'(owner) == N_MST - 1) ? '0 : owner + PW'(1);
            end
         end
         default: state_next = ARB_IDLE;
      endcase
      if (rst) grant = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
         ptr   <= '0;
         owner <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         owner <= owner_next;
      end
   end

endmodule

// File: rtl/avalon_crossbar.sv
// N-master x M-slave Avalon-MM crossbar with address-window decode, per-slave
// arbitration and a one-cycle error response for unmapped accesses.
module avalon_crossbar
   import avalon_xbar_pkg::*;
#(
   parameter int                   N_MST    = 3,
   parameter int                   N_SLV    = 6,
   parameter int                   AW       = 32,
   parameter int                   DW       = 32,
   parameter logic [N_SLV*AW-1:0]  SLV_BASE = '0,
   parameter logic [N_SLV*AW-1:0]  SLV_MASK = '0,
   parameter int                   ARB_MODE = ARB_RR
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_MST-1:0]          m_read,
   input  logic [N_MST-1:0]          m_write,
   input  logic [N_MST*AW-1:0]       m_address,
   input  logic [N_MST*DW/8-1:0]     m_byte_enable,
   input  logic [N_MST*DW-1:0]       m_writedata,
   output logic [N_MST*DW-1:0]       m_readdata,
   output logic [N_MST-1:0]          m_waitrequest,
   output logic [N_SLV-1:0]          s_read,
   output logic [N_SLV-1:0]          s_write,
   output logic [N_SLV*AW-1:0]       s_address,
   output logic [N_SLV*DW/8-1:0]     s_byte_enable,
   output logic [N_SLV*DW-1:0]       s_writedata,
   input  logic [N_SLV*DW-1:0]       s_readdata,
   input  logic [N_SLV-1:0]          s_waitrequest,
   output logic [N_MST-1:0]          decode_err
);

   localparam int BW = DW / 8;

   logic [N_MST-1:0] active, hit, err_pend;
   logic [N_MST-1:0] slv_req   [N_SLV];
   logic [N_MST-1:0] slv_grant [N_SLV];

   assign active = m_read | m_write;

   // First matching window claims the master, so overlapping maps favour low slaves.
   always_comb begin
      hit = '0;
      for (int s = 0; s < N_SLV; s++) slv_req[s] = '0;
      for (int m = 0; m < N_MST; m++) begin
         for (int s = 0; s < N_SLV; s++) begin
            if (!hit[m] && ((m_address[m*AW +: AW] & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW])) begin
               hit[m]        = 1'b1;
               slv_req[s][m] = active[m];
            end
         end
      end
   end

   for (genvar s = 0; s < N_SLV; s++) begin : g_slv
      avalon_xbar_arbiter #(
         .N_MST    (N_MST),
         .ARB_MODE (ARB_MODE)
      ) u_arb (
         .clk         (clk),
         .rst         (rst),
         .req         (slv_req[s]),
         .waitrequest (s_waitrequest[s]),
         .grant       (slv_grant[s])
      );
   end

   always_comb begin
      s_read        = '0;
      s_write       = '0;
      s_address     = '0;
      s_byte_enable = '0;
      s_writedata   = '0;
      for (int s = 0; s < N_SLV; s++) begin
         for (int m = 0; m < N_MST; m++) begin
            if (slv_grant[s][m]) begin
               s_read[s]                  = m_read[m];
               s_write[s]                 = m_write[m];
               s_address[s*AW +: AW]      = m_address[m*AW +: AW];
               s_byte_enable[s*BW +: BW]  = m_byte_enable[m*BW +: BW];
               s_writedata[s*DW +: DW]    = m_writedata[m*DW +: DW];
            end
         end
      end
   end

   // A pending decode error completes the transfer with zero data, overriding the stall.
   always_comb begin
      m_readdata    = '0;
      m_waitrequest = '1;
      decode_err    = '0;
      for (int m = 0; m < N_MST; m++) begin
         for (int s = 0; s < N_SLV; s++) begin
            if (slv_grant[s][m]) begin
               m_waitrequest[m]       = s_waitrequest[s];
               m_readdata[m*DW +: DW] = s_readdata[s*DW +: DW];
            end
         end
         if (err_pend[m] && !rst) begin
            m_waitrequest[m] = 1'b0;
            decode_err[m]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_pend <= '0;
      else     err_pend <= ~err_pend & active & ~hit;
   end

endmodule
